calc_sequencer: RTL and testbench

- Instruction-level controller for the calculator's 4x8-bit register file and its external combinational ALU.
- Accepts one instruction at a time over a valid/ready handshake: load-immediate, two-operand ALU op, move, or NOP.
- Sequences the register file's single read port (RA/X) over successive cycles, feeds the ALU operand registers, and issues the write-back.
- Sits between the front-end (keypad/switch decode) and the register file + ALU pair.

---
 rtl/calc_sequencer_if.sv | 36 +++
 rtl/calc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_sequencer_if
// Instruction handshake bundle between the calculator front-end (keypad/switch
// decode) and calc_sequencer.
//   in_valid : instruction present (front-end -> sequencer)
//   in_ready : sequencer can accept an instruction (sequencer -> front-end)
//   in_op    : 000 NOP, 001 LDI, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR,
//              111 MOV
//   in_rd    : destination register
//   in_ra    : source A
//   in_rb    : source B
//   in_imm   : immediate for LDI
// Modports: master = front-end, slave = sequencer.
// -----------------------------------------------------------------------------
interface calc_sequencer_if #(
  parameter int DW = 8,
  parameter int RW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [RW-1:0] in_rd;
  logic [RW-1:0] in_ra;
  logic [RW-1:0] in_rb;
  logic [DW-1:0] in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm,
    output in_ready
  );
endinterface

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Instruction-level controller for the calculator's 4x8-bit register file and
// its external combinational ALU. Takes one instruction at a time, walks the
// register file's single read port over successive cycles to fill the ALU
// operand registers, then issues the write-back.
//
// Ports:
//   clk, rst   : clock (sequencer on posedge, register file on negedge) and
//                synchronous active-high reset
//   cmd        : instruction handshake (calc_sequencer_if.slave)
//   rf_ra      : register file address
//   rf_wr/rf_rd: register file control (rd=0 no write; wr=0,rd=1 load rf_din;
//                wr=1,rd=1 load ALU result)
//   rf_din     : register file DATA_INPUT (immediate for LDI)
//   rf_x       : register file X output, R[rf_ra] latched at the prior negedge
//   alu_op     : ALU function during write-back (111 = pass-A)
//   alu_a/alu_b: registered ALU operands
//   res_alu    : combinational ALU result
//   done       : one-cycle retirement pulse
//   result     : value written by the last retired instruction
//   zero       : result == 0
//   instr_cnt  : retired-instruction counter
//
// Build option: define CALC_SEQ_INSTR_CNT_EN to include the 16-bit retired
// instruction counter; otherwise instr_cnt is tied to zero.
// -----------------------------------------------------------------------------
module calc_sequencer #(
  parameter int DW = 8,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst,
  calc_sequencer_if.slave cmd,
  output logic [RW-1:0] rf_ra,
  output logic          rf_wr,
  output logic          rf_rd,
  output logic [DW-1:0] rf_din,
  input  logic [DW-1:0] rf_x,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] res_alu,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic [15:0]   instr_cnt
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_WB, S_DONE} state_t;

  state_t        state, state_n;
  logic          in_ready_c;
  logic [2:0]    op_q;
  logic [RW-1:0] rd_q, ra_q, rb_q;
  logic [DW-1:0] imm_q;

  assign cmd.in_ready = in_ready_c;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Instruction fields are captured only on acceptance; nothing is buffered
  // while busy.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cmd.in_valid) begin
      op_q  <= cmd.in_op;
      rd_q  <= cmd.in_rd;
      ra_q  <= cmd.in_ra;
      rb_q  <= cmd.in_rb;
      imm_q <= cmd.in_imm;
    end
  end

  // Operand capture: rf_x already holds R[rf_ra] from the mid-cycle negedge.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
    end else begin
      if (state == S_RDA) begin
        alu_a <= rf_x;
        if (op_q == OP_MOV) alu_b <= '0;
      end
      if (state == S_RDB) alu_b <= rf_x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 result <= '0;
    else if (state == S_WB)  result <= (op_q == OP_LDI) ? imm_q : res_alu;
  end

  assign zero = (result == '0);

`ifdef CALC_SEQ_INSTR_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                  cnt_q <= '0;
    else if (state == S_DONE) cnt_q <= cnt_q + 16'd1;
  end
  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

  // Write controls and done are masked by rst so that a reset landing in WB
  // blocks the negedge write and a reset landing in DONE does not retire.
  always_comb begin
    state_n    = state;
    in_ready_c = 1'b0;
    rf_ra      = '0;
    rf_rd      = 1'b0;
    rf_wr      = 1'b0;
    rf_din     = '0;
    alu_op     = 3'b000;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (cmd.in_valid) begin
          case (cmd.in_op)
            OP_NOP:  state_n = S_DONE;
            OP_LDI:  state_n = S_WB;
            default: state_n = S_RDA;
          endcase
        end
      end
      S_RDA: begin
        rf_ra   = ra_q;
        state_n = (op_q == OP_MOV) ? S_WB : S_RDB;
      end
      S_RDB: begin
        rf_ra   = rb_q;
        state_n = S_WB;
      end
      S_WB: begin
        rf_ra = rd_q;
        rf_rd = ~rst;
        if (op_q == OP_LDI) begin
          rf_din = imm_q;
        end else begin
          rf_wr  = ~rst;
          alu_op = op_q;
        end
        state_n = S_DONE;
      end
      S_DONE: begin
        done    = ~rst;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
// Directed bench for calc_sequencer with a negedge register file model and a
// combinational ALU model. Expected results come from an architectural model
// of the four registers and are queued at issue, popped at done.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

  localparam logic [2:0] NOP = 3'b000, LDI = 3'b001, ADD = 3'b010, SUB = 3'b011,
                         AND_ = 3'b100, OR_ = 3'b101, XOR_ = 3'b110, MOV = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rf_ra;
  logic       rf_wr, rf_rd;
  logic [7:0] rf_din, rf_x, alu_a, alu_b, res_alu, result;
  logic [2:0] alu_op;
  logic       done, zero;
  logic [15:0] instr_cnt;

  calc_sequencer_if #(.DW(8), .RW(2)) cmd_if ();

  calc_sequencer #(.DW(8), .RW(2)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if),
    .rf_ra(rf_ra), .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_din(rf_din), .rf_x(rf_x),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .res_alu(res_alu),
    .done(done), .result(result), .zero(zero), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Register file: updates and X latch on negedge.
  logic [7:0] rf_mem [4];
  always @(negedge clk) begin
    if (rf_rd) rf_mem[rf_ra] <= rf_wr ? res_alu : rf_din;
    rf_x <= rf_mem[rf_ra];
  end

  // External ALU.
  always_comb begin
    res_alu = 8'h00;
    case (alu_op)
      ADD:  res_alu = alu_a + alu_b;
      SUB:  res_alu = alu_a - alu_b;
      AND_: res_alu = alu_a & alu_b;
      OR_:  res_alu = alu_a | alu_b;
      XOR_: res_alu = alu_a ^ alu_b;
      MOV:  res_alu = alu_a;
      default: res_alu = 8'h00;
    endcase
  end

  int         checks = 0;
  int         errors = 0;
  int         n_ret = 0;
  logic [7:0] m [4];
  logic [7:0] last_res = 8'h00;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ADD:  return a + b;
      SUB:  return a - b;
      AND_: return a & b;
      OR_:  return a | b;
      XOR_: return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef CALC_SEQ_INSTR_CNT_EN
    return 16'(n_ret);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm);
    cmd_if.in_valid = v;
    cmd_if.in_op    = op;
    cmd_if.in_rd    = rd;
    cmd_if.in_ra    = ra;
    cmd_if.in_rb    = rb;
    cmd_if.in_imm   = imm;
  endtask

  // Issue one instruction from IDLE (called #1 after a posedge) and follow it
  // to retirement, checking per-cycle controls against the instruction shape.
  task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                       input bit inject);
    int         lat;
    logic [7:0] e;
    logic [1:0] era;
    logic [7:0] exp_res;
    bit         is_alu, seen;
    is_alu = (op != NOP) && (op != LDI);
    case (op)
      NOP:     begin lat = 1; e = last_res; end
      LDI:     begin lat = 2; e = imm; end
      MOV:     begin lat = 3; e = m[ra]; end
      default: begin lat = 4; e = alu_ref(op, m[ra], m[rb]); end
    endcase
    if (op != NOP) m[rd] = e;
    last_res = e;
    exp_q.push_back(e);

    check({tag, " in_ready_idle"}, 32'(cmd_if.in_ready), 32'd1);
    drive(1'b1, op, rd, ra, rb, imm);
    @(posedge clk); #1;
    drive(1'b0, NOP, 2'd0, 2'd0, 2'd0, 8'h00);
    seen = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      if (inject && k == 2) drive(1'b1, LDI, 2'd1, 2'd1, 2'd1, 8'hFF);
      era = 2'd0;
      if (op == LDI && k == 1) era = rd;
      if (op == MOV) era = (k == 1) ? ra : (k == 2) ? rd : 2'd0;
      if (is_alu && op != MOV) era = (k == 1) ? ra : (k == 2) ? rb : (k == 3) ? rd : 2'd0;
      check({tag, " in_ready_busy"}, 32'(cmd_if.in_ready), 32'd0);
      check({tag, " rf_ra"}, 32'(rf_ra), 32'(era));
      check({tag, " rf_rd"}, 32'(rf_rd), 32'((op != NOP) && k == lat - 1));
      check({tag, " rf_wr"}, 32'(rf_wr), 32'(is_alu && k == lat - 1));
      check({tag, " rf_din"}, 32'(rf_din), 32'((op == LDI && k == 1) ? imm : 8'h00));
      check({tag, " alu_op"}, 32'(alu_op), 32'((is_alu && k == lat - 1) ? op : 3'b000));
      check({tag, " done_timing"}, 32'(done), 32'(k == lat));
      if (done === 1'b1) begin
        seen = 1;
        n_ret++;
        exp_res = exp_q.pop_front();
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " zero"}, 32'(zero), 32'(exp_res == 8'h00));
        drive(1'b0, NOP, 2'd0, 2'd0, 2'd0, 8'h00);
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout observed=no_done expected=done_within_8", tag);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    check({tag, " idle_ready"}, 32'(cmd_if.in_ready), 32'd1);
    check({tag, " idle_done"}, 32'(done), 32'd0);
    check({tag, " instr_cnt"}, 32'(instr_cnt), 32'(exp_cnt()));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, NOP, 2'd0, 2'd0, 2'd0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst in_ready", 32'(cmd_if.in_ready), 32'd1);
      check("rst done", 32'(done), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst zero", 32'(zero), 32'd1);
      check("rst rf_rd", 32'(rf_rd), 32'd0);
      check("rst rf_wr", 32'(rf_wr), 32'd0);
      check("rst alu_ab", 32'({alu_a, alu_b}), 32'd0);
      check("rst instr_cnt", 32'(instr_cnt), 32'd0);
      @(posedge clk); #1;
    end

    issue("ldi_r1", LDI, 2'd1, 2'd0, 2'd0, 8'h25, 0);
    issue("ldi_r0", LDI, 2'd0, 2'd0, 2'd0, 8'h10, 0);
    issue("add_r2", ADD, 2'd2, 2'd1, 2'd0, 8'h00, 0);
    issue("nop", NOP, 2'd0, 2'd0, 2'd0, 8'h00, 0);
    issue("ldi_r3", LDI, 2'd3, 2'd0, 2'd0, 8'h00, 0);
    issue("sub_r3", SUB, 2'd3, 2'd3, 2'd1, 8'h00, 1);
    issue("xor_r3", XOR_, 2'd3, 2'd3, 2'd3, 8'h00, 0);
    issue("mov_r3", MOV, 2'd3, 2'd1, 2'd0, 8'h00, 0);
    issue("or_r3", OR_, 2'd3, 2'd0, 2'd1, 8'h00, 0);
    issue("and_r3", AND_, 2'd3, 2'd2, 2'd1, 8'h00, 0);

    // Abort ADD R2=R1+R1 with reset during write-back.
    drive(1'b1, ADD, 2'd2, 2'd1, 2'd1, 8'h00);
    @(posedge clk); #1;
    drive(1'b0, NOP, 2'd0, 2'd0, 2'd0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort wb rf_rd", 32'(rf_rd), 32'd1);
    check("abort wb rf_ra", 32'(rf_ra), 32'd2);
    rst = 1'b1;
    #1;
    check("abort rf_rd_masked", 32'(rf_rd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_ret = 0;
    last_res = 8'h00;
    check("abort in_ready", 32'(cmd_if.in_ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort zero", 32'(zero), 32'd1);
    check("abort instr_cnt", 32'(instr_cnt), 32'd0);
    @(posedge clk); #1;
    check("abort no_late_done", 32'(done), 32'd0);

    issue("mov_r0_r2", MOV, 2'd0, 2'd2, 2'd0, 8'h00, 0);
    issue("mov_r1_chk", MOV, 2'd1, 2'd1, 2'd0, 8'h00, 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
